// File: rtl/ext_mem_responder_pkg.sv
// Shared definitions for the external burst memory responder: beat geometry,
// address field offsets and the one-hot controller state encoding.
package ext_mem_responder_pkg;

  localparam int EXT_BEATS  = 4;
  localparam int EXT_BEAT_W = 128;
  localparam int EXT_MASK_W = 16;
  localparam int LINE_LSB   = 6;
  localparam int WORD_LSB   = 4;
  localparam int WORD_W     = 2;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_WR_BURST = 5'b00010,
    ST_RD_WAIT  = 5'b00100,
    ST_RD_BURST = 5'b01000,
    ST_ACK      = 5'b10000
  } state_e;

  // Critical-word-first ordering: beat idx of a line read starting at word base.
  function automatic logic [WORD_W-1:0] wrap_word(input logic [WORD_W-1:0] base,
                                                   input logic [WORD_W-1:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/ext_mem_responder_array.sv
// Line-organised backing SRAM: one 128-bit word per address, byte write mask,
// registered read data. Contents are never reset.
module ext_mem_array
  import ext_mem_responder_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [EXT_MASK_W-1:0] mask,
  input  logic [EXT_BEAT_W-1:0] wdat,
  output logic [EXT_BEAT_W-1:0] rdat_p1
);

  logic [EXT_BEAT_W-1:0] mem [DEPTH];

  // Byte-masked write and synchronous read on the single port.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < EXT_MASK_W; b++) begin
        if (mask[b]) mem[addr][b*8 +: 8] <= wdat[b*8 +: 8];
      end
    end
    if (re) rdat_p1 <= mem[addr];
  end

endmodule

// File: rtl/ext_mem_responder.sv
// Memory-side responder for the external burst bus: 4-beat masked write bursts,
// critical-word-first line reads after a fixed latency, one transaction at a time.
module ext_mem_responder
  import ext_mem_responder_pkg::*;
#(
  parameter int MEM_LINES  = 1024,
  parameter int RD_LAT     = 4,
  parameter int PHY_ADDR_W = 34
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_mem_ext_wren,
  input  logic                  i_mem_ext_rden,
  input  logic [EXT_MASK_W-1:0] i_mem_ext_mask,
  input  logic [2:0]            i_mem_ext_burst,
  input  logic [PHY_ADDR_W-1:0] i_mem_ext_paddr,
  input  logic [EXT_BEAT_W-1:0] i_mem_ext_wdat,
  input  logic                  i_mem_ext_burst_start,
  input  logic                  i_mem_ext_burst_end,
  input  logic                  i_mem_ext_burst_vld,
  output logic                  o_ext_mmu_rd_vld,
  output logic [EXT_BEAT_W-1:0] o_ext_mmu_rdat,
  output logic                  o_ext_mmu_rd_ack,
  output logic                  o_ext_mmu_wr_ack,
  output logic                  o_ext_mmu_err,
  output logic                  o_ext_busy
);

  localparam int LINE_W = $clog2(MEM_LINES);
  localparam int ADDR_W = LINE_W + WORD_W;

  state_e              state, state_n;
  logic [3:0]          lat_cnt, lat_n;
  logic [LINE_W-1:0]   line_r, line_n;
  logic [WORD_W-1:0]   word_r, word_n;
  logic [WORD_W-1:0]   beat_r, beat_n;
  logic [2:0]          exp_r, exp_n;
  logic                err_r, err_n;
  logic                oor_r, oor_n;

  logic                mem_we, mem_re;
  logic [ADDR_W-1:0]   mem_addr;
  logic [EXT_BEAT_W-1:0] arr_rdat_p1;

  logic [LINE_W-1:0]   line_in;
  logic [WORD_W-1:0]   word_in;
  logic                oor_in;
  logic                unused_paddr_lsbs;

  assign line_in           = i_mem_ext_paddr[LINE_LSB +: LINE_W];
  assign word_in           = i_mem_ext_paddr[WORD_LSB +: WORD_W];
  assign oor_in            = |(i_mem_ext_paddr >> (LINE_LSB + LINE_W));
  assign unused_paddr_lsbs = ^i_mem_ext_paddr[WORD_LSB-1:0];

  // Control registers; only these see reset, the array keeps its contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
      line_r  <= '0;
      word_r  <= '0;
      beat_r  <= '0;
      exp_r   <= '0;
      err_r   <= 1'b0;
      oor_r   <= 1'b0;
    end else begin
      state   <= state_n;
      lat_cnt <= lat_n;
      line_r  <= line_n;
      word_r  <= word_n;
      beat_r  <= beat_n;
      exp_r   <= exp_n;
      err_r   <= err_n;
      oor_r   <= oor_n;
    end
  end

  // Next-state decode plus array port steering; reads are issued a cycle ahead
  // of the beat so the returned data comes straight from the array flop.
  always_comb begin
    state_n  = state;
    lat_n    = lat_cnt;
    line_n   = line_r;
    word_n   = word_r;
    beat_n   = beat_r;
    exp_n    = exp_r;
    err_n    = err_r;
    oor_n    = oor_r;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = {line_r, word_r};
    unique case (state)
      ST_IDLE: begin
        if (i_mem_ext_burst_vld && i_mem_ext_burst_start) begin
          if (i_mem_ext_rden && !i_mem_ext_wren) begin
            line_n  = line_in;
            word_n  = word_in;
            oor_n   = oor_in;
            lat_n   = 4'(RD_LAT - 1);
            state_n = ST_RD_WAIT;
          end else if (i_mem_ext_wren && !i_mem_ext_rden && i_mem_ext_burst == 3'd1) begin
            line_n = line_in;
            oor_n  = oor_in;
            exp_n  = 3'd2;
            if (i_mem_ext_burst_end) begin
              err_n   = 1'b1;
              state_n = ST_ACK;
            end else begin
              mem_we   = !oor_in;
              mem_addr = {line_in, 2'd0};
              state_n  = ST_WR_BURST;
            end
          end else if (i_mem_ext_wren) begin
            err_n   = 1'b1;
            state_n = ST_ACK;
          end
        end
      end
      ST_WR_BURST: begin
        if (i_mem_ext_burst_vld && i_mem_ext_wren) begin
          if (i_mem_ext_burst == exp_r &&
              !(i_mem_ext_burst_end && i_mem_ext_burst != 3'(EXT_BEATS))) begin
            mem_we   = !oor_r;
            mem_addr = {line_r, exp_r[1:0] - 2'd1};
            exp_n    = exp_r + 3'd1;
            if (i_mem_ext_burst_end) begin
              err_n   = oor_r;
              state_n = ST_ACK;
            end
          end else begin
            err_n   = 1'b1;
            state_n = ST_ACK;
          end
        end
      end
      ST_RD_WAIT: begin
        if (lat_cnt == 4'd0) begin
          mem_re   = 1'b1;
          mem_addr = {line_r, word_r};
          beat_n   = 2'd0;
          state_n  = ST_RD_BURST;
        end else begin
          lat_n = lat_cnt - 4'd1;
        end
      end
      ST_RD_BURST: begin
        if (beat_r == 2'd3) begin
          state_n = ST_IDLE;
        end else begin
          mem_re   = 1'b1;
          mem_addr = {line_r, wrap_word(word_r, beat_r + 2'd1)};
          beat_n   = beat_r + 2'd1;
        end
      end
      ST_ACK: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    // A reset cycle must not disturb the array.
    if (!rst_n) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  ext_mem_array #(
    .DEPTH (MEM_LINES * EXT_BEATS),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .we     (mem_we),
    .re     (mem_re),
    .addr   (mem_addr),
    .mask   (i_mem_ext_mask),
    .wdat   (i_mem_ext_wdat),
    .rdat_p1(arr_rdat_p1)
  );

  assign o_ext_busy       = (state != ST_IDLE);
  assign o_ext_mmu_rd_vld = (state == ST_RD_BURST);
  assign o_ext_mmu_rd_ack = (state == ST_RD_BURST) && (beat_r == 2'd3);
  assign o_ext_mmu_wr_ack = (state == ST_ACK);
  assign o_ext_mmu_err    = ((state == ST_ACK) && err_r) || (o_ext_mmu_rd_ack && oor_r);
  assign o_ext_mmu_rdat   = (o_ext_mmu_rd_vld && !oor_r) ? arr_rdat_p1 : '0;

endmodule
